// File: rtl/mux7_rr_sched.sv
// Round-robin scheduler driving the select of a shared 7-to-1 bit mux.
// Bounded hold per grant; registered grant, select, busy and mux output.
module mux7_rr_sched #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] req,
  input  logic [6:0] din,
  output logic [6:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       dout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] hold_q, hold_d;
  logic [6:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic       dout_q, dout_d;

  logic [3:0] win_all, win_oth;
  logic       own_req, do_grant;
  logic [2:0] grant_idx;

  // {found, index} of the first set bit of r searching p, p+1, ... mod 7
  function automatic logic [3:0] pick(input logic [6:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [3:0] s;
    res = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      s = {1'b0, p} + 4'(i);
      if (s >= 4'd7) s = s - 4'd7;
      if (!res[3] && r[s[2:0]]) res = {1'b1, s[2:0]};
    end
    return res;
  endfunction

  function automatic logic [2:0] inc7(input logic [2:0] k);
    return (k == 3'd6) ? 3'd0 : k + 3'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    dout_d    = busy_q ? din[sel_q] : 1'b0;
    own_req   = req[sel_q];
    win_all   = pick(req, ptr_q);
    win_oth   = pick(req & ~(7'b1 << sel_q), ptr_q);
    do_grant  = 1'b0;
    grant_idx = sel_q;

    unique case (state_q)
      IDLE: begin
        if (win_all[3]) begin
          do_grant  = 1'b1;
          grant_idx = win_all[2:0];
        end
      end
      GRANT: begin
        if (own_req && (hold_q < 4'(MAX_HOLD - 1))) begin
          hold_d = hold_q + 4'd1;
        end else if (!own_req) begin
          if (win_all[3]) begin
            do_grant  = 1'b1;
            grant_idx = win_all[2:0];
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else begin
          // expiry: owner masked; it is re-granted only if nobody else asks
          do_grant  = 1'b1;
          grant_idx = win_oth[3] ? win_oth[2:0] : sel_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_grant) begin
      state_d = GRANT;
      gnt_d   = 7'b1 << grant_idx;
      sel_d   = grant_idx;
      busy_d  = 1'b1;
      hold_d  = '0;
      ptr_d   = inc7(grant_idx);
    end
  end

  always_comb begin
    gnt  = gnt_q;
    sel  = sel_q;
    busy = busy_q;
    dout = dout_q;
  end

endmodule

// File: tb/tb_mux7_rr_sched.sv
// Bench for mux7_rr_sched: three instances (MAX_HOLD 4, 2, 1) checked
// against directed expectations and a queue-free arbitration model.
module tb_mux7_rr_sched;

  logic       clk;
  logic       rst_n;
  logic [6:0] req;
  logic [6:0] din;

  logic [6:0] gnt_o  [3];
  logic [2:0] sel_o  [3];
  logic       busy_o [3];
  logic       dout_o [3];

  int n_checks;
  int n_fail;

  int mh     [3] = '{4, 2, 1};
  int m_own  [3];
  int m_ptr  [3];
  int m_hold [3];
  int m_sel  [3];
  int m_dout [3];

  mux7_rr_sched #(.MAX_HOLD(4)) u_h4 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt_o[0]), .sel(sel_o[0]), .busy(busy_o[0]), .dout(dout_o[0]));
  mux7_rr_sched #(.MAX_HOLD(2)) u_h2 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt_o[1]), .sel(sel_o[1]), .busy(busy_o[1]), .dout(dout_o[1]));
  mux7_rr_sched #(.MAX_HOLD(1)) u_h1 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt_o[2]), .sel(sel_o[2]), .busy(busy_o[2]), .dout(dout_o[2]));

  always #5 clk = ~clk;

  // first active requester of r in rotating order starting at p, or -1
  function automatic int first_from(input logic [6:0] r, input int p);
    for (int i = 0; i < 7; i++) begin
      if (r[(p + i) % 7]) return (p + i) % 7;
    end
    return -1;
  endfunction

  function automatic void model_grant(input int n, input int j);
    m_own[n]  = j;
    m_sel[n]  = j;
    m_hold[n] = 0;
    m_ptr[n]  = (j + 1) % 7;
  endfunction

  function automatic void model_edge(input int n, input logic [6:0] r,
                                     input logic [6:0] d, input logic rn);
    int k;
    int w;
    logic [6:0] others;
    m_dout[n] = (rn && m_own[n] >= 0) ? int'(d[m_sel[n]]) : 0;
    if (!rn) begin
      m_own[n] = -1; m_ptr[n] = 0; m_hold[n] = 0; m_sel[n] = 0;
    end else if (m_own[n] < 0) begin
      w = first_from(r, m_ptr[n]);
      if (w >= 0) model_grant(n, w);
    end else begin
      k = m_own[n];
      if (r[k] && m_hold[n] < mh[n] - 1) begin
        m_hold[n]++;
      end else if (!r[k]) begin
        w = first_from(r, m_ptr[n]);
        if (w >= 0) model_grant(n, w);
        else m_own[n] = -1;
      end else begin
        others = r;
        others[k] = 1'b0;
        w = first_from(others, m_ptr[n]);
        model_grant(n, (w >= 0) ? w : k);
      end
    end
  endfunction

  task automatic step(input logic [6:0] r, input logic [6:0] d, input logic rn);
    req = r; din = d; rst_n = rn;
    @(posedge clk);
    for (int n = 0; n < 3; n++) model_edge(n, r, d, rn);
    #1;
  endtask

  task automatic test_reset;
    for (int c = 0; c < 3; c++) begin
      step(7'h7F, 7'h7F, 1'b0);
      for (int n = 0; n < 3; n++) begin
        n_checks++;
        if (gnt_o[n] !== 7'h00 || sel_o[n] !== 3'd0 || dout_o[n] !== 1'b0 || busy_o[n] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_hold inst%0d cyc%0d: gnt=%h sel=%0d busy=%b dout=%b, want 00/0/0/0",
                   n, c, gnt_o[n], sel_o[n], busy_o[n], dout_o[n]);
        end
      end
    end
    step(7'h7F, 7'h00, 1'b1);
    for (int n = 0; n < 3; n++) begin
      n_checks++;
      if (gnt_o[n] !== 7'h01 || sel_o[n] !== 3'd0 || busy_o[n] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_release inst%0d: gnt=%h sel=%0d busy=%b, want 01/0/1",
                 n, gnt_o[n], sel_o[n], busy_o[n]);
      end
    end
  endtask

  task automatic test_single;
    step(7'h00, 7'h00, 1'b0);
    step(7'h20, 7'h20, 1'b1);
    n_checks++;
    if (gnt_o[0] !== 7'h20 || sel_o[0] !== 3'd5 || busy_o[0] !== 1'b1 || dout_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%h sel=%0d busy=%b dout=%b, want 20/5/1/0",
               gnt_o[0], sel_o[0], busy_o[0], dout_o[0]);
    end
    for (int c = 0; c < 12; c++) begin
      step(7'h20, 7'h20, 1'b1);
      n_checks++;
      if (gnt_o[0] !== 7'h20 || dout_o[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL single_hold cyc%0d: gnt=%h dout=%b, want 20/1", c, gnt_o[0], dout_o[0]);
      end
    end
    step(7'h00, 7'h20, 1'b1);
    n_checks++;
    if (busy_o[0] !== 1'b0 || gnt_o[0] !== 7'h00 || dout_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_drop: busy=%b gnt=%h dout=%b, want 0/00/1", busy_o[0], gnt_o[0], dout_o[0]);
    end
    step(7'h00, 7'h20, 1'b1);
    n_checks++;
    if (dout_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_dout_idle: dout=%b, want 0", dout_o[0]);
    end
  endtask

  task automatic test_all_hold2;
    logic [6:0] exp_g;
    step(7'h00, 7'h00, 1'b0);
    for (int c = 0; c < 16; c++) begin
      step(7'h7F, 7'h00, 1'b1);
      exp_g = 7'b1 << ((c / 2) % 7);
      n_checks++;
      if (gnt_o[1] !== exp_g || sel_o[1] !== 3'((c / 2) % 7)) begin
        n_fail++;
        $display("FAIL all_hold2 cyc%0d: gnt=%h sel=%0d, want %h/%0d",
                 c, gnt_o[1], sel_o[1], exp_g, (c / 2) % 7);
      end
    end
  endtask

  task automatic test_early_release;
    step(7'h00, 7'h00, 1'b0);
    step(7'h08, 7'h00, 1'b1);
    step(7'h48, 7'h00, 1'b1);
    n_checks++;
    if (gnt_o[0] !== 7'h08) begin
      n_fail++;
      $display("FAIL early_owner3: gnt=%h, want 08", gnt_o[0]);
    end
    step(7'h40, 7'h00, 1'b1);
    n_checks++;
    if (gnt_o[0] !== 7'h40 || sel_o[0] !== 3'd6 || busy_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL early_switch: gnt=%h sel=%0d busy=%b, want 40/6/1", gnt_o[0], sel_o[0], busy_o[0]);
    end
    step(7'h01, 7'h00, 1'b1);
    n_checks++;
    if (gnt_o[0] !== 7'h01 || sel_o[0] !== 3'd0) begin
      n_fail++;
      $display("FAIL early_wrap: gnt=%h sel=%0d, want 01/0", gnt_o[0], sel_o[0]);
    end
  endtask

  task automatic test_fair_wrap;
    logic [6:0] exp_g;
    step(7'h00, 7'h00, 1'b0);
    step(7'h20, 7'h00, 1'b1);
    step(7'h00, 7'h00, 1'b1);
    for (int c = 0; c < 12; c++) begin
      step(7'h41, 7'h00, 1'b1);
      exp_g = ((c / 4) % 2 == 0) ? 7'h40 : 7'h01;
      n_checks++;
      if (gnt_o[0] !== exp_g) begin
        n_fail++;
        $display("FAIL fair_wrap cyc%0d: gnt=%h, want %h", c, gnt_o[0], exp_g);
      end
    end
  endtask

  task automatic test_reset_mid;
    step(7'h00, 7'h00, 1'b0);
    for (int c = 0; c < 3; c++) step(7'h10, 7'h00, 1'b1);
    step(7'h30, 7'h00, 1'b0);
    n_checks++;
    if (gnt_o[0] !== 7'h00 || busy_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_drop: gnt=%h busy=%b, want 00/0", gnt_o[0], busy_o[0]);
    end
    step(7'h30, 7'h00, 1'b1);
    n_checks++;
    if (gnt_o[0] !== 7'h10 || sel_o[0] !== 3'd4) begin
      n_fail++;
      $display("FAIL reset_mid_regrant: gnt=%h sel=%0d, want 10/4", gnt_o[0], sel_o[0]);
    end
  endtask

  task automatic test_random;
    logic [6:0] r;
    logic       rn;
    logic [6:0] exp_g;
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 7; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      rn = ($urandom_range(0, 99) != 0);
      step(r, 7'($urandom), rn);
      for (int n = 0; n < 3; n++) begin
        exp_g = (m_own[n] < 0) ? 7'h00 : (7'b1 << m_own[n]);
        n_checks++;
        if (gnt_o[n] !== exp_g || sel_o[n] !== 3'(m_sel[n]) ||
            busy_o[n] !== (m_own[n] >= 0) || dout_o[n] !== 1'(m_dout[n]) || !$onehot0(gnt_o[n])) begin
          n_fail++;
          $display("FAIL random inst%0d cyc%0d: gnt=%h sel=%0d busy=%b dout=%b, want %h/%0d/%b/%0d",
                   n, c, gnt_o[n], sel_o[n], busy_o[n], dout_o[n],
                   exp_g, m_sel[n], (m_own[n] >= 0), m_dout[n]);
        end
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; req = '0; din = '0;
    n_checks = 0; n_fail = 0;
    for (int n = 0; n < 3; n++) begin
      m_own[n] = -1; m_ptr[n] = 0; m_hold[n] = 0; m_sel[n] = 0; m_dout[n] = 0;
    end
    test_reset;
    test_single;
    test_all_hold2;
    test_early_release;
    test_fair_wrap;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
